// File: rtl/gerador_pwm_pkg.sv
// Shared constants and helpers for the PWM generator and
// the BCD duty conversion used by the display path.
package gerador_pwm_pkg;

   localparam int PASSOS_PWM   = 100;
   localparam int BCD_MAX      = 9;
   localparam int LARGURA_DUTY = 7;

   typedef logic [LARGURA_DUTY-1:0] duty_t;

   localparam duty_t RAMPA_MAX = duty_t'(PASSOS_PWM - 1);

   function automatic logic [3:0] satura_bcd(input logic [3:0] d);
      return (d > 4'(BCD_MAX)) ? 4'(BCD_MAX) : d;
   endfunction

endpackage

// File: rtl/bcd_para_binario.sv
// Two BCD digits to binary, each digit clamped to 9.
// Shared between the PWM duty path and the display path.
module bcd_para_binario
   import gerador_pwm_pkg::*;
(
   input  logic [3:0] dezena_i,
   input  logic [3:0] unidade_i,
   output duty_t      binario_o
);

   logic [3:0] dez;
   logic [3:0] uni;

   always_comb begin
      dez       = satura_bcd(dezena_i);
      uni       = satura_bcd(unidade_i);
      binario_o = duty_t'(dez) * 7'd10 + duty_t'(uni);
   end

endmodule

// File: rtl/gerador_pwm.sv
// PWM generator: prescaled 0..99 ramp compared against a
// duty value that is only latched at period boundaries.
module gerador_pwm
   import gerador_pwm_pkg::*;
#(
   parameter int DIVISOR = 500
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic       habilitar,
   input  logic [3:0] duty_dezena,
   input  logic [3:0] duty_unidade,
   output logic       led,
   output logic       fim_periodo,
   output duty_t      duty_atual
);

   localparam int LP = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [LP-1:0] P_MAX = LP'(DIVISOR - 1);

   logic [LP-1:0] p_q, p_d;
   duty_t         r_q, r_d;
   duty_t         duty_q, duty_d;
   logic          led_q, led_d;
   logic          fim_q, fim_d;
   duty_t         duty_bin;
   logic          tick;
   logic          wrap;

   bcd_para_binario u_bcd (
      .dezena_i  (duty_dezena),
      .unidade_i (duty_unidade),
      .binario_o (duty_bin)
   );

   assign tick = habilitar && (p_q == P_MAX);
   assign wrap = tick && (r_q == RAMPA_MAX);

   always_comb begin
      p_d    = p_q;
      r_d    = r_q;
      duty_d = duty_q;
      led_d  = 1'b0;
      fim_d  = 1'b0;
      if (!habilitar) begin
         // Track the input so a re-enable starts with the current duty.
         p_d    = '0;
         r_d    = '0;
         duty_d = duty_bin;
      end else begin
         p_d   = tick ? '0 : p_q + 1'b1;
         led_d = (r_q < duty_q);
         fim_d = wrap;
         if (tick) begin
            r_d = (r_q == RAMPA_MAX) ? '0 : r_q + 1'b1;
         end
         if (wrap) begin
            duty_d = duty_bin;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         p_q    <= '0;
         r_q    <= '0;
         duty_q <= '0;
         led_q  <= 1'b0;
         fim_q  <= 1'b0;
      end else begin
         p_q    <= p_d;
         r_q    <= r_d;
         duty_q <= duty_d;
         led_q  <= led_d;
         fim_q  <= fim_d;
      end
   end

   assign led         = led_q;
   assign fim_periodo = fim_q;
   assign duty_atual  = duty_q;

endmodule

// File: tb/tb_gerador_pwm.sv
// Directed bench for gerador_pwm with DIVISOR=4 and a
// queue of expected values popped as results are measured.
module tb_gerador_pwm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       hab;
   logic [3:0] dez;
   logic [3:0] uni;
   logic       led;
   logic       fim;
   logic [6:0] duty_atual;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string tag;
      int    v;
   } exp_t;

   exp_t exp_q[$];

   gerador_pwm #(.DIVISOR(4)) dut (
      .clock        (clk),
      .reset        (rst_n),
      .habilitar    (hab),
      .duty_dezena  (dez),
      .duty_unidade (uni),
      .led          (led),
      .fim_periodo  (fim),
      .duty_atual   (duty_atual)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(input string tag, input int v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      exp_q.push_back(e);
   endtask

   task automatic got(input int obs);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed %0d expected none", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", e.tag, obs, e.v);
         end
      end
   endtask

   // One period window: samples after a fim pulse up to and
   // including the next fim pulse (bounded at 1000 cycles).
   task automatic measure(input int chg, input logic [3:0] nd,
                          input logic [3:0] nu, output int len,
                          output int hi, output int fhi,
                          output int flo, output int dv);
      len = 0;
      hi  = 0;
      fhi = -1;
      flo = -1;
      if (chg == 0) begin
         dez = nd;
         uni = nu;
      end
      while (len < 1000) begin
         step();
         len++;
         if (led) begin
            hi++;
            if (fhi < 0) fhi = len;
         end else if (flo < 0) begin
            flo = len;
         end
         if (len == chg) begin
            dez = nd;
            uni = nu;
         end
         if (fim) break;
      end
      dv = int'(duty_atual);
   endtask

   task automatic period(input string t, input int chg,
                         input logic [3:0] nd, input logic [3:0] nu,
                         input int e_hi, input int e_fhi,
                         input int e_flo, input int e_dv);
      int len, hi, fhi, flo, dv;
      expect_v({t, "_len"}, 400);
      expect_v({t, "_hi"}, e_hi);
      expect_v({t, "_first_hi"}, e_fhi);
      expect_v({t, "_first_lo"}, e_flo);
      expect_v({t, "_duty"}, e_dv);
      measure(chg, nd, nu, len, hi, fhi, flo, dv);
      got(len);
      got(hi);
      got(fhi);
      got(flo);
      got(dv);
   endtask

   initial begin
      rst_n = 1'b0;
      hab   = 1'b1;
      dez   = 4'd4;
      uni   = 4'd5;
      repeat (3) step();

      expect_v("rst_led", 0);
      expect_v("rst_fim", 0);
      expect_v("rst_duty", 0);
      got(int'(led));
      got(int'(fim));
      got(int'(duty_atual));

      rst_n = 1'b1;
      period("first", -1, 4'd4, 4'd5, 0, -1, 1, 45);
      period("d45", 0, 4'd2, 4'd5, 180, 1, 181, 25);
      period("d25", -1, 4'd2, 4'd5, 100, 1, 101, 25);
      period("chg", 40, 4'd7, 4'd0, 100, 1, 101, 70);
      period("d70", -1, 4'd7, 4'd0, 280, 1, 281, 70);
      period("to0", 0, 4'd0, 4'd0, 280, 1, 281, 0);
      period("d0", 0, 4'd12, 4'd15, 0, -1, 1, 99);
      period("d99", 0, 4'd1, 4'd15, 396, 1, 397, 19);
      period("d19", 0, 4'd3, 4'd0, 76, 1, 77, 30);

      repeat (100) step();
      expect_v("pre_dis_led", 1);
      got(int'(led));
      hab = 1'b0;
      step();
      expect_v("dis_led", 0);
      got(int'(led));
      repeat (49) step();
      expect_v("dis_led_hold", 0);
      expect_v("dis_fim", 0);
      expect_v("dis_duty", 30);
      got(int'(led));
      got(int'(fim));
      got(int'(duty_atual));
      hab = 1'b1;
      period("reen", -1, 4'd3, 4'd0, 120, 1, 121, 30);

      repeat (20) step();
      expect_v("pre_rst_led", 1);
      got(int'(led));
      #2;
      rst_n = 1'b0;
      #1;
      expect_v("async_led", 0);
      expect_v("async_fim", 0);
      expect_v("async_duty", 0);
      got(int'(led));
      got(int'(fim));
      got(int'(duty_atual));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gerador_pwm.md
# gerador_pwm

PWM generator that consumes the two-digit BCD duty value (00–99) produced by the mod-100 duty counter and drives the `led` output. A prescaled 0–99 ramp is compared against the duty value. New duty values are taken only at period boundaries, so a button press never produces a glitched period. The block sits directly downstream of the duty counter and in parallel with the 7-segment display decoders.

## Interface
Parameters:
- `DIVISOR`, default 500: clock cycles per ramp step, legal range ≥1. Period is 100·DIVISOR cycles, i.e. 1 kHz at 50 MHz.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low; one clock domain only.
- `habilitar`  in  1  run enable; when low the ramp is held at 0 and `led` is forced low.
- `duty_dezena`  in  4  BCD tens digit of the duty value.
- `duty_unidade`  in  4  BCD units digit of the duty value.
- `led`  out  1  registered PWM output.
- `fim_periodo`  out  1  single-cycle pulse marking the start of a new period.
- `duty_atual`  out  7  binary duty currently in force (0–99).

## Operation
- Conversion (combinational): each digit >9 is clamped to 9; `duty_bin = dezena·10 + unidade`, 7 bits, maximum 99.
- Prescaler `p` counts 0..DIVISOR−1. `tick` = (`p` == DIVISOR−1) while `habilitar` is high.
- Ramp `r` (7 bits) advances on `tick`: if r == 99 then r←0, else r←r+1.
- Period wrap: on `tick` with r == 99, `duty_atual` ← `duty_bin` and `fim_periodo` ← 1. In every other cycle `fim_periodo` ← 0.
- Output: `led` ← (r < `duty_atual`), evaluated on pre-edge values.
- `habilitar` low, on each edge:
  - p←0, r←0
  - `led`←0, `fim_periodo`←0
  - `duty_atual`←`duty_bin`, tracked continuously so the duty applies immediately on re-enable.
- Duty input changes mid-period are ignored until the next wrap (shadow behaviour).
- Duty 0 gives `led` constantly low. Duty 99 gives `led` high for 99 of 100 steps. 100 % is not reachable by design.

## Timing
- Reset asserted, asynchronously: p=0, r=0, `duty_atual`=0, `led`=0, `fim_periodo`=0.
- First period after reset release runs with duty 0. The sampled duty applies from the second period.
- `led` lags the ramp by exactly one clock. High time per period is exactly `duty_atual`·DIVISOR cycles; low time is (100−`duty_atual`)·DIVISOR cycles.
- `fim_periodo` goes high in the cycle following the edge where r wraps 99→0. It is coincident with the first cycle in which `duty_atual` shows the new value.
- The first `led` rise after the wrap occurs one cycle after `fim_periodo`, provided the new duty is >0.
- `fim_periodo` spacing is exactly 100·DIVISOR cycles while `habilitar` stays high.
- Re-enable: `habilitar` rising gives `led` high one clock later if `duty_bin` >0. The first `fim_periodo` follows 100·DIVISOR cycles after re-enable.
- `habilitar` falling mid-period: `led` is low one clock later and the ramp is restarted, not resumed.
- Reset asserted mid-period: all outputs clear immediately. The in-flight duty update is lost.
- DIVISOR=1: `tick` fires every cycle and the period is 100 cycles.

## Structure
- Shared package/include holds:
  - constant `PASSOS_PWM = 100`
  - constant `BCD_MAX = 9`
  - ramp/duty width `LARGURA_DUTY = 7`
- Sub-module `bcd_para_binario` is combinational: two 4-bit digits in, clamped 7-bit binary out. The display path reuses it.
- Top level holds the prescaler, ramp, shadow register and output register.

## Test plan
- Run all scenarios with DIVISOR=4.
- Reset: hold `reset`=0 with duty 45 → `led`=0, `fim_periodo`=0, `duty_atual`=0. After release, the first period is all-low and the first `fim_periodo` occurs at cycle 400.
- Steady duty: inputs 2,5 (dezena, unidade) → `duty_atual`=25 after the first wrap. `led` is high for 100 cycles and low for 300 cycles per period. `fim_periodo` pulses every 400 cycles.
- Mid-period change: duty 25→70 at ramp step 10 → the current period keeps 100 high cycles. The next period has 280 high cycles, and `duty_atual`=70 coincides with `fim_periodo`.
- Extremes: duty 00 → `led` is never high. Duty 99 → `led` is low only 4 cycles per period, and those are the cycles following r=99.
- Invalid BCD: inputs 12,15 (dezena, unidade) → `duty_atual`=99.
- Enable: `habilitar`=0 for 50 cycles mid-period with duty 30 → `led`=0 one clock after the fall. On the rise, `led` goes high one clock later for 120 cycles. Async reset mid-high → `led` drops without waiting for a clock edge.
